// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, FSM state type and instruction field positions
// for the Hack-style CPU controller.
package cpu_pkg;

    localparam int PC_W   = 15;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 16;

    localparam int TYPE_BIT = 15;
    localparam int A_BIT    = 12;
    localparam int COMP_HI  = 11;
    localparam int COMP_LO  = 6;
    localparam int DEST_HI  = 5;
    localparam int DEST_LO  = 3;
    localparam int JUMP_HI  = 2;
    localparam int JUMP_LO  = 0;

    typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;

    // jump bits are {lt, eq, gt}
    function automatic logic jump_taken(input logic [2:0] jump, input logic zr, input logic ng);
        return (jump[2] & ng) | (jump[1] & zr) | (jump[0] & ~ng & ~zr);
    endfunction

endpackage

// File: rtl/hack_alu.sv
// hack_alu: combinational Hack ALU; comp = {zx, nx, zy, ny, f, no}.
module hack_alu
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic [5:0]        comp,
    output logic [DATA_W-1:0] result,
    output logic              zr,
    output logic              ng
);

    logic [DATA_W-1:0] x_z, x_n, y_z, y_n, f_out;

    assign x_z    = comp[5] ? '0 : x;
    assign x_n    = comp[4] ? ~x_z : x_z;
    assign y_z    = comp[3] ? '0 : y;
    assign y_n    = comp[2] ? ~y_z : y_z;
    assign f_out  = comp[1] ? x_n + y_n : x_n & y_n;
    assign result = comp[0] ? ~f_out : f_out;
    assign zr     = result == '0;
    assign ng     = result[DATA_W-1];

endmodule

// File: rtl/cpu_control.sv
// cpu_control: IDLE/FETCH/EXEC sequencer for a Hack-style CPU; fetches from
// ROM, decodes A/C instructions and drives the register/memory write enables.
module cpu_control
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              rom_req,
    output logic [PC_W-1:0]   rom_addr,
    input  logic              rom_valid,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0] addr,
    output logic              reg_a_en,
    output logic              reg_d_en,
    output logic              reg_m_en,
    output logic [DATA_W-1:0] data_out,
    input  logic [DATA_W-1:0] reg_a_in,
    input  logic [DATA_W-1:0] reg_d_in,
    input  logic [DATA_W-1:0] reg_m_in,
    output logic [PC_W-1:0]   pc,
    output logic              halted
);

    state_t            state, state_nxt;
    logic [PC_W-1:0]   pc_nxt;
    logic [DATA_W-1:0] ir, ir_nxt, result;
    logic              zr, ng;

    hack_alu u_alu (
        .x      (reg_d_in),
        .y      (ir[A_BIT] ? reg_m_in : reg_a_in),
        .comp   (ir[COMP_HI:COMP_LO]),
        .result (result),
        .zr     (zr),
        .ng     (ng)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
        end
    end

    // addr and jump target both come from the pre-instruction A value
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        reg_a_en  = 1'b0;
        reg_d_en  = 1'b0;
        reg_m_en  = 1'b0;
        case (state)
            IDLE:  state_nxt = run ? FETCH : IDLE;
            FETCH: begin
                if (rom_valid) begin
                    ir_nxt    = rom_data;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = run ? FETCH : IDLE;
                if (ir[TYPE_BIT]) begin
                    {reg_a_en, reg_d_en, reg_m_en} = ir[DEST_HI:DEST_LO];
                    pc_nxt = jump_taken(ir[JUMP_HI:JUMP_LO], zr, ng) ? reg_a_in[PC_W-1:0] : pc + 1'b1;
                end else begin
                    reg_a_en = 1'b1;
                    pc_nxt   = pc + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rom_req  = state == FETCH;
    assign rom_addr = pc;
    assign halted   = state == IDLE;
    assign addr     = reg_a_in[ADDR_W-1:0];
    assign data_out = ir[TYPE_BIT] ? result : ir;

endmodule

// File: tb/tb_cpu_control.sv
// tb_cpu_control: directed vectors with hand-computed expectations for cpu_control.
module tb_cpu_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        rom_req;
    logic [14:0] rom_addr;
    logic        rom_valid = 1'b0;
    logic [15:0] rom_data = '0;
    logic [12:0] addr;
    logic        reg_a_en, reg_d_en, reg_m_en;
    logic [15:0] data_out;
    logic [15:0] reg_a_in = '0, reg_d_in = '0, reg_m_in = '0;
    logic [14:0] pc;
    logic        halted;

    int n_vec = 0;
    int n_err = 0;

    cpu_control dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .rom_req   (rom_req),
        .rom_addr  (rom_addr),
        .rom_valid (rom_valid),
        .rom_data  (rom_data),
        .addr      (addr),
        .reg_a_en  (reg_a_en),
        .reg_d_en  (reg_d_en),
        .reg_m_en  (reg_m_en),
        .data_out  (data_out),
        .reg_a_in  (reg_a_in),
        .reg_d_in  (reg_d_in),
        .reg_m_in  (reg_m_in),
        .pc        (pc),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present one instruction while in FETCH; returns in EXEC
    task automatic fetch(input logic [15:0] instr);
        rom_valid = 1'b1;
        rom_data  = instr;
        tick();
        rom_valid = 1'b0;
        rom_data  = 16'h0000;
        #1;
    endtask

    function automatic logic [31:0] ens();
        return {29'd0, reg_a_en, reg_d_en, reg_m_en};
    endfunction

    initial begin
        #3;
        chk("rst_halted", halted, 1);
        chk("rst_pc", pc, 0);
        chk("rst_req", rom_req, 0);
        chk("rst_en", ens(), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_hold", halted, 1);

        run = 1'b1;
        tick();
        chk("fetch_req", rom_req, 1);
        chk("fetch_addr0", rom_addr, 0);
        fetch(16'h0005);
        chk("ainst_en", ens(), 3'b100);
        chk("ainst_data", data_out, 16'h0005);
        tick();
        chk("ainst_pc", pc, 1);
        reg_a_in = 16'h0005;
        fetch(16'hEC10);
        chk("deqa_en", ens(), 3'b010);
        chk("deqa_data", data_out, 16'h0005);
        tick();
        chk("deqa_pc", pc, 2);

        reg_a_in = 16'h0010;
        reg_d_in = 16'h0007;
        fetch(16'hE7C8);
        chk("mdp1_en", ens(), 3'b001);
        chk("mdp1_addr", addr, 13'h0010);
        chk("mdp1_data", data_out, 16'h0008);
        tick();
        chk("mdp1_pc", pc, 3);

        reg_a_in = 16'h0003;
        fetch(16'hEA87);
        chk("jmp_en", ens(), 0);
        tick();
        chk("jmp_addr", rom_addr, 3);
        reg_d_in = 16'h0000;
        fetch(16'hE301);
        tick();
        chk("jgt_not_taken", pc, 4);

        for (int i = 0; i < 4; i++) begin
            chk("stall_req", rom_req, 1);
            chk("stall_addr", rom_addr, 4);
            chk("stall_en", ens(), 0);
            tick();
        end

        reg_a_in = 16'h0010;
        reg_d_in = 16'h0007;
        fetch(16'hE7C8);
        chk("pre_rst_en", ens(), 3'b001);
        rst_n = 1'b0;
        #1;
        chk("rst_exec_en", ens(), 0);
        chk("rst_exec_pc", pc, 0);
        chk("rst_exec_halted", halted, 1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("refetch_addr0", rom_addr, 0);

        fetch(16'h7FFF);
        tick();
        reg_a_in = 16'h7FFF;
        fetch(16'hEA87);
        tick();
        chk("at_top_pc", pc, 15'h7FFF);
        run = 1'b0;
        tick();
        chk("run_drop_fetch", rom_req, 1);
        fetch(16'h0001);
        chk("run_drop_exec_en", ens(), 3'b100);
        tick();
        chk("wrap_pc", pc, 0);
        chk("run_drop_halted", halted, 1);
        tick();
        chk("stay_idle", halted, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
